bram_read_responder: RTL and testbench

Services the periodic read-request / slot-boundary pulses produced by the peripheral FPGA's BRAM pacing counter. For each request it issues one BRAM read and waits out the BRAM read latency. It captures the pixel and releases it to the downstream SPI transmit path at the next slot boundary, using a valid/ready handshake. It owns the frame pixel address, which wraps at the end of a 1280x720 frame.

---
 rtl/bram_read_responder_pkg.sv | 30 +++
 rtl/bram_read_responder_addr_counter.sv | 43 ++++
 rtl/bram_read_responder.sv | 175 +++++++++++++++++
 tb/tb_bram_read_responder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bram_read_responder_pkg.sv
// ---------------------------------------------------------------------------
// bram_read_responder_pkg
// Shared types and constants for the BRAM read responder.
//   state_e              : FSM state encoding (IDLE, WAIT, HOLD, PRESENT)
//   FRAME_WIDTH/HEIGHT   : 1280x720 frame geometry
//   DEFAULT_FRAME_PIXELS : pixels per frame for the default build
//   next_addr()          : pixel address increment with end-of-frame wrap
// ---------------------------------------------------------------------------
package bram_read_responder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    HOLD    = 2'd2,
    PRESENT = 2'd3
  } state_e;

  localparam int unsigned FRAME_WIDTH          = 1280;
  localparam int unsigned FRAME_HEIGHT         = 720;
  localparam int unsigned DEFAULT_FRAME_PIXELS = FRAME_WIDTH * FRAME_HEIGHT;

  // Address after 'addr'; the last pixel of the frame wraps back to pixel 0.
  function automatic int unsigned next_addr(
    input int unsigned addr,
    input int unsigned frame_pixels = DEFAULT_FRAME_PIXELS
  );
    return (addr >= frame_pixels - 1) ? 0 : addr + 1;
  endfunction

endpackage

// File: rtl/bram_read_responder_addr_counter.sv
// ---------------------------------------------------------------------------
// frame_addr_counter
// Frame pixel address register. Advances by one (with wrap at the end of the
// frame) on each cycle advance_i is high; returns to 0 on reset.
// Ports:
//   clk_i      system clock
//   rst_i      asynchronous active-high reset
//   advance_i  step to the next pixel address this cycle
//   addr_o     current pixel address
// ---------------------------------------------------------------------------
module frame_addr_counter
  import bram_read_responder_pkg::*;
#(
  parameter int unsigned FRAME_PIXELS = DEFAULT_FRAME_PIXELS,
  parameter int          ADDR_WIDTH   = $clog2(FRAME_PIXELS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  advance_i,
  output logic [ADDR_WIDTH-1:0] addr_o
);

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_d;

  always_comb begin
    addr_d = addr_q;
    if (advance_i) begin
      addr_d = ADDR_WIDTH'(next_addr(32'(addr_q), FRAME_PIXELS));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/bram_read_responder.sv
// ---------------------------------------------------------------------------
// bram_read_responder
// Turns read-request / slot-boundary pulses from the BRAM pacing counter into
// one BRAM read per request, holds the returned pixel, and releases it to the
// SPI transmit path at the next slot boundary over a valid/ready handshake.
// The frame pixel address advances only when a pixel is accepted downstream.
//
// Optional feature macro: BRAM_READ_RESPONDER_REPEAT_EN
//   When defined, a slot boundary with no pixel held (IDLE or WAIT) re-presents
//   the last delivered word (frame_start_out=0, no address advance), then the
//   FSM resumes the state it left. When undefined, such a boundary only sets
//   underrun_out.
//
// Ports:
//   clk_in           system clock
//   rst_in           asynchronous active-high reset
//   read_request_in  pulse: start a BRAM read
//   hit_max_in       pulse: slot boundary, release held pixel
//   bram_addr_out    BRAM read address
//   bram_en_out      BRAM read enable, one cycle per read
//   bram_data_in     BRAM read data
//   data_out         pixel to SPI transmitter
//   data_valid_out   data_out valid
//   data_ready_in    downstream accepts data_out
//   frame_start_out  data_out is pixel 0 of a frame
//   underrun_out     sticky: slot boundary with no pixel held
//   overrun_out      sticky: read request while busy
// ---------------------------------------------------------------------------
module bram_read_responder
  import bram_read_responder_pkg::*;
#(
  parameter int unsigned FRAME_PIXELS = DEFAULT_FRAME_PIXELS,
  parameter int          DATA_WIDTH   = 16,
  parameter int          BRAM_LATENCY = 2
) (
  input  logic                                   clk_in,
  input  logic                                   rst_in,
  input  logic                                   read_request_in,
  input  logic                                   hit_max_in,
  output logic [$clog2(FRAME_PIXELS)-1:0]        bram_addr_out,
  output logic                                   bram_en_out,
  input  logic [DATA_WIDTH-1:0]                  bram_data_in,
  output logic [DATA_WIDTH-1:0]                  data_out,
  output logic                                   data_valid_out,
  input  logic                                   data_ready_in,
  output logic                                   frame_start_out,
  output logic                                   underrun_out,
  output logic                                   overrun_out
);

  localparam int ADDR_WIDTH = $clog2(FRAME_PIXELS);

  state_e                state_q;
  logic [3:0]            lat_cnt_q;   // BRAM_LATENCY is at most 8
  logic [DATA_WIDTH-1:0] hold_q;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  advance;

`ifdef BRAM_READ_RESPONDER_REPEAT_EN
  logic   delivered_q;   // at least one pixel accepted since reset
  logic   repeat_q;      // current presentation is a repeat of data_out
  state_e ret_state_q;   // state to resume after the repeat handshake
  assign advance = data_valid_out && data_ready_in && !repeat_q;
`else
  assign advance = data_valid_out && data_ready_in;
`endif

  frame_addr_counter #(
    .FRAME_PIXELS (FRAME_PIXELS),
    .ADDR_WIDTH   (ADDR_WIDTH)
  ) u_addr (
    .clk_i     (clk_in),
    .rst_i     (rst_in),
    .advance_i (advance),
    .addr_o    (addr)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q         <= IDLE;
      lat_cnt_q       <= '0;
      hold_q          <= '0;
      bram_addr_out   <= '0;
      bram_en_out     <= 1'b0;
      data_out        <= '0;
      data_valid_out  <= 1'b0;
      frame_start_out <= 1'b0;
      underrun_out    <= 1'b0;
      overrun_out     <= 1'b0;
`ifdef BRAM_READ_RESPONDER_REPEAT_EN
      delivered_q     <= 1'b0;
      repeat_q        <= 1'b0;
      ret_state_q     <= IDLE;
`endif
    end else begin
      bram_en_out <= 1'b0;

      if (read_request_in && (state_q != IDLE)) begin
        overrun_out <= 1'b1;
      end
      if (hit_max_in && ((state_q == IDLE) || (state_q == WAIT))) begin
        underrun_out <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (read_request_in) begin
            bram_en_out   <= 1'b1;
            bram_addr_out <= addr;
            // The counter spans the enable cycle as well, so reaching zero
            // lands on the cycle in which BRAM data is valid.
            lat_cnt_q     <= 4'(BRAM_LATENCY);
            state_q       <= WAIT;
          end
`ifdef BRAM_READ_RESPONDER_REPEAT_EN
          else if (hit_max_in && delivered_q) begin
            // data_out still carries the last delivered word
            data_valid_out  <= 1'b1;
            frame_start_out <= 1'b0;
            repeat_q        <= 1'b1;
            ret_state_q     <= IDLE;
            state_q         <= PRESENT;
          end
`endif
        end

        WAIT: begin
`ifdef BRAM_READ_RESPONDER_REPEAT_EN
          if (hit_max_in && delivered_q) begin
            // Counter frozen for the repeat; the BRAM output holds its word.
            data_valid_out  <= 1'b1;
            frame_start_out <= 1'b0;
            repeat_q        <= 1'b1;
            ret_state_q     <= WAIT;
            state_q         <= PRESENT;
          end else
`endif
          if (lat_cnt_q == 4'd0) begin
            hold_q  <= bram_data_in;
            state_q <= HOLD;
          end else begin
            lat_cnt_q <= lat_cnt_q - 4'd1;
          end
        end

        HOLD: begin
          if (hit_max_in) begin
            data_out        <= hold_q;
            data_valid_out  <= 1'b1;
            // Address only advances on handshake, so it still names this pixel.
            frame_start_out <= (addr == '0);
            state_q         <= PRESENT;
          end
        end

        PRESENT: begin
          if (data_ready_in) begin
            data_valid_out  <= 1'b0;
            frame_start_out <= 1'b0;
`ifdef BRAM_READ_RESPONDER_REPEAT_EN
            delivered_q     <= 1'b1;
            repeat_q        <= 1'b0;
            state_q         <= repeat_q ? ret_state_q : IDLE;
`else
            state_q         <= IDLE;
`endif
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_read_responder.sv
// ---------------------------------------------------------------------------
// tb_bram_read_responder
// Directed bench for bram_read_responder, small-frame build (FRAME_PIXELS=4)
// with BRAM_LATENCY=2. The BRAM model returns addr + 16'hA000 two cycles
// after the enable cycle and holds its output until the next read.
// ---------------------------------------------------------------------------
module tb_bram_read_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read_request = 1'b0;
  logic        hit_max = 1'b0;
  logic [1:0]  bram_addr;
  logic        bram_en;
  logic [15:0] bram_data = 16'h0000;
  logic [15:0] data;
  logic        data_valid;
  logic        data_ready = 1'b1;
  logic        frame_start;
  logic        underrun;
  logic        overrun;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bram_read_responder #(
    .FRAME_PIXELS (4),
    .DATA_WIDTH   (16),
    .BRAM_LATENCY (2)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .read_request_in (read_request),
    .hit_max_in      (hit_max),
    .bram_addr_out   (bram_addr),
    .bram_en_out     (bram_en),
    .bram_data_in    (bram_data),
    .data_out        (data),
    .data_valid_out  (data_valid),
    .data_ready_in   (data_ready),
    .frame_start_out (frame_start),
    .underrun_out    (underrun),
    .overrun_out     (overrun)
  );

  // Two-cycle BRAM: address registered on the enable edge, data registered
  // one edge later.
  logic       en_d1   = 1'b0;
  logic [1:0] addr_d1 = 2'd0;
  always @(posedge clk) begin
    en_d1   <= bram_en;
    addr_d1 <= bram_addr;
    if (en_d1) bram_data <= 16'hA000 + {14'd0, addr_d1};
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request one read and confirm the enable pulse and address.
  task automatic issue(input string tag, input logic [1:0] exp_addr);
    read_request = 1'b1;
    tick();
    read_request = 1'b0;
    check_eq({tag, " bram_en"}, 32'(bram_en), 32'd1);
    check_eq({tag, " bram_addr"}, 32'(bram_addr), 32'(exp_addr));
    $display("issue %s addr=%0d", tag, bram_addr);
  endtask

  // Slot boundary while a pixel is held: expect it presented next cycle.
  task automatic present(input string tag, input logic [15:0] exp_data, input logic exp_fs);
    hit_max = 1'b1;
    tick();
    hit_max = 1'b0;
    check_eq({tag, " valid"}, 32'(data_valid), 32'd1);
    check_eq({tag, " data"}, 32'(data), 32'(exp_data));
    check_eq({tag, " frame_start"}, 32'(frame_start), 32'(exp_fs));
    $display("present %s data=%h fs=%0d", tag, data, frame_start);
  endtask

  initial begin
    // ---- reset state ----
    repeat (3) tick();
    check_eq("rst bram_en", 32'(bram_en), 32'd0);
    check_eq("rst bram_addr", 32'(bram_addr), 32'd0);
    check_eq("rst data", 32'(data), 32'd0);
    check_eq("rst valid", 32'(data_valid), 32'd0);
    check_eq("rst frame_start", 32'(frame_start), 32'd0);
    check_eq("rst underrun", 32'(underrun), 32'd0);
    check_eq("rst overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    repeat (6) tick();

    // ---- pixel 0: basic read, ready held high ----
    issue("p0", 2'd0);
    repeat (3) tick();
    check_eq("p0 no early valid", 32'(data_valid), 32'd0);
    present("p0", 16'hA000, 1'b1);
    tick();
    check_eq("p0 valid drop", 32'(data_valid), 32'd0);
    check_eq("p0 no underrun", 32'(underrun), 32'd0);

    // ---- pixel 1: back-pressure for 5 cycles ----
    issue("p1", 2'd1);
    repeat (3) tick();
    data_ready = 1'b0;
    present("p1", 16'hA001, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("p1 stall valid", 32'(data_valid), 32'd1);
      check_eq("p1 stall data", 32'(data), 32'hA001);
    end
    data_ready = 1'b1;
    tick();
    check_eq("p1 valid drop", 32'(data_valid), 32'd0);

    // ---- pixel 2: request during PRESENT is an overrun ----
    issue("p2", 2'd2);
    repeat (3) tick();
    data_ready = 1'b0;
    present("p2", 16'hA002, 1'b0);
    read_request = 1'b1;
    tick();
    read_request = 1'b0;
    check_eq("ovr bram_en", 32'(bram_en), 32'd0);
    check_eq("ovr flag", 32'(overrun), 32'd1);
    check_eq("ovr valid held", 32'(data_valid), 32'd1);
    data_ready = 1'b1;
    tick();

    // ---- pixel 3, then wrap to pixel 0 ----
    issue("p3", 2'd3);
    repeat (3) tick();
    present("p3", 16'hA003, 1'b0);
    tick();

`ifdef BRAM_READ_RESPONDER_REPEAT_EN
    // ---- repeat of the last delivered word with no request ----
    hit_max = 1'b1;
    tick();
    hit_max = 1'b0;
    check_eq("rep valid", 32'(data_valid), 32'd1);
    check_eq("rep data", 32'(data), 32'hA003);
    check_eq("rep frame_start", 32'(frame_start), 32'd0);
    check_eq("rep underrun", 32'(underrun), 32'd1);
    $display("repeat data=%h", data);
    tick();
    check_eq("rep valid drop", 32'(data_valid), 32'd0);
`endif

    issue("p4 wrap", 2'd0);
    repeat (3) tick();
    present("p4 wrap", 16'hA000, 1'b1);
    tick();

`ifndef BRAM_READ_RESPONDER_REPEAT_EN
    // ---- boundary during WAIT: underrun, pixel waits for next boundary ----
    check_eq("pre underrun", 32'(underrun), 32'd0);
    issue("p5", 2'd1);
    hit_max = 1'b1;
    tick();
    hit_max = 1'b0;
    check_eq("udr flag", 32'(underrun), 32'd1);
    check_eq("udr no valid", 32'(data_valid), 32'd0);
    repeat (4) tick();
    check_eq("udr still held", 32'(data_valid), 32'd0);
    present("p5", 16'hA001, 1'b0);
    tick();
    issue("p6", 2'd2);
`else
    issue("p6", 2'd1);
`endif

    // ---- asynchronous reset during the enable cycle ----
    #2 rst = 1'b1;
    #1;
    check_eq("arst bram_en", 32'(bram_en), 32'd0);
    check_eq("arst bram_addr", 32'(bram_addr), 32'd0);
    check_eq("arst underrun", 32'(underrun), 32'd0);
    check_eq("arst overrun", 32'(overrun), 32'd0);
    check_eq("arst valid", 32'(data_valid), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    repeat (2) tick();
    issue("p7 post-rst", 2'd0);
    repeat (3) tick();
    present("p7 post-rst", 16'hA000, 1'b1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
